// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler fetch block: FSM state encoding and window width helper.
package scaler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitConn,
        StIssue,
        StDrain,
        StRowEnd
    } fetch_state_e;

    function automatic int unsigned win_bits(input int unsigned pix_bits,
                                             input int unsigned kernel);
        return pix_bits * kernel * kernel;
    endfunction

endpackage

// File: rtl/scaler_fetch_fifo.sv
// Synchronous show-ahead FIFO holding kept read responses until the consumer takes them.
module scaler_fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/scaler_matrix_fetch.sv
// Walks output pixels of a scaled frame, issuing column reads to the matrix RAM and
// forwarding the kept response windows with their fractional phases.
module scaler_matrix_fetch
    import scaler_pkg::*;
#(
    parameter int unsigned PIXEL_BITWIDTH = 8,
    parameter int unsigned KERNEL_MAX     = 4,
    parameter int unsigned IMG_BITWIDTH   = 12,
    parameter int unsigned FRAC_BITWIDTH  = 16,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                                              core_clk,
    input  logic                                              core_rst,
    input  logic                                              core_start,
    input  logic [IMG_BITWIDTH-1:0]                           cfg_dst_width,
    input  logic [IMG_BITWIDTH-1:0]                           cfg_dst_height,
    input  logic [IMG_BITWIDTH+FRAC_BITWIDTH-1:0]             cfg_h_step,
    input  logic [IMG_BITWIDTH+FRAC_BITWIDTH-1:0]             cfg_v_step,
    output logic                                              m_axis_connect_ready,
    input  logic                                              m_axis_connect_valid,
    output logic                                              matrix_ram_read_en,
    output logic                                              matrix_ram_read_stride,
    output logic                                              matrix_ram_read_repeat,
    input  logic                                              matrix_ram_read_rsp_en,
    input  logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0]   matrix_ram_read_rsp_pixel,
    output logic                                              matrix_ram_read_done,
    output logic [IMG_BITWIDTH-1:0]                           matrix_row_step,
    output logic                                              m_win_valid,
    input  logic                                              m_win_ready,
    output logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0]   m_win_pixel,
    output logic [FRAC_BITWIDTH-1:0]                          m_win_hphase,
    output logic [FRAC_BITWIDTH-1:0]                          m_win_vphase,
    output logic                                              m_win_eol,
    output logic                                              m_win_eof,
    output logic                                              busy
);
    localparam int unsigned WIN_BITS = win_bits(PIXEL_BITWIDTH, KERNEL_MAX);
    localparam int unsigned ACC_BITS = IMG_BITWIDTH + FRAC_BITWIDTH;
    localparam int unsigned CNT_W    = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int unsigned FIFO_W   = WIN_BITS + 2 * FRAC_BITWIDTH + 2;

    fetch_state_e            r_state;
    logic [IMG_BITWIDTH-1:0] r_dst_w, r_dst_h, r_col, r_row, r_reads_left, r_rsp_col;
    logic [ACC_BITS-1:0]     r_h_step, r_v_step, r_h_acc, r_v_acc, r_rsp_hacc;
    logic                    r_pix_stride, r_pix_repeat;
    logic [CNT_W-1:0]        r_kept_inflight;
    logic [IMG_BITWIDTH-1:0] r_skip_inflight;
    logic                    r_connect_ready, r_read_en, r_read_stride, r_read_repeat;
    logic                    r_read_done, r_busy;
    logic [IMG_BITWIDTH-1:0] r_row_step;

    logic [CNT_W-1:0]        w_fifo_count;
    logic                    w_fifo_valid;
    logic [FIFO_W-1:0]       w_fifo_out, w_head, w_push_data;
    logic [CNT_W:0]          w_used;
    logic                    w_last_read, w_issue, w_issue_kept, w_issue_skip;
    logic                    w_rsp_keep, w_rsp_discard, w_rsp_eol, w_rsp_eof;
    logic [ACC_BITS-1:0]     w_next_hacc, w_next_vacc;
    logic [IMG_BITWIDTH-1:0] w_delta;

    assign w_used      = {1'b0, w_fifo_count} + {1'b0, r_kept_inflight};
    assign w_last_read = (r_reads_left == IMG_BITWIDTH'(1));
    // Skip reads wait until no kept read is outstanding, so every response in flight is
    // ordered as skips followed by kepts and a skip counter alone classifies responses.
    assign w_issue      = (r_state == StIssue) &&
                          (w_last_read ? (w_used < (CNT_W + 1)'(RSP_FIFO_DEPTH))
                                       : (r_kept_inflight == '0));
    assign w_issue_kept = w_issue && w_last_read;
    assign w_issue_skip = w_issue && !w_last_read;

    assign w_rsp_discard = matrix_ram_read_rsp_en && (r_skip_inflight != '0);
    assign w_rsp_keep    = matrix_ram_read_rsp_en && (r_skip_inflight == '0) &&
                           (r_kept_inflight != '0);

    assign w_next_hacc = r_h_acc + r_h_step;
    assign w_next_vacc = r_v_acc + r_v_step;
    assign w_delta     = w_next_hacc[ACC_BITS-1:FRAC_BITWIDTH] - r_h_acc[ACC_BITS-1:FRAC_BITWIDTH];
    assign w_rsp_eol   = (r_rsp_col == r_dst_w - IMG_BITWIDTH'(1));
    assign w_rsp_eof   = w_rsp_eol && (r_row == r_dst_h - IMG_BITWIDTH'(1));
    assign w_push_data = {matrix_ram_read_rsp_pixel, r_rsp_hacc[FRAC_BITWIDTH-1:0],
                          r_v_acc[FRAC_BITWIDTH-1:0], w_rsp_eol, w_rsp_eof};

    scaler_fetch_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (core_clk),
        .i_rst   (core_rst),
        .i_push  (w_rsp_keep),
        .i_data  (w_push_data),
        .i_pop   (m_win_ready),
        .o_data  (w_fifo_out),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state <= StIdle;
            {r_dst_w, r_dst_h, r_col, r_row, r_reads_left, r_rsp_col} <= '0;
            {r_h_step, r_v_step, r_h_acc, r_v_acc, r_rsp_hacc}        <= '0;
            {r_pix_stride, r_pix_repeat}                              <= '0;
            r_kept_inflight <= '0;
            r_skip_inflight <= '0;
            {r_connect_ready, r_read_en, r_read_stride, r_read_repeat} <= '0;
            {r_read_done, r_busy} <= '0;
            r_row_step <= '0;
        end else begin
            r_read_en     <= 1'b0;
            r_read_stride <= 1'b0;
            r_read_repeat <= 1'b0;
            r_read_done   <= 1'b0;

            case ({w_issue_kept, w_rsp_keep})
                2'b10:   r_kept_inflight <= r_kept_inflight + CNT_W'(1);
                2'b01:   r_kept_inflight <= r_kept_inflight - CNT_W'(1);
                default: r_kept_inflight <= r_kept_inflight;
            endcase
            case ({w_issue_skip, w_rsp_discard})
                2'b10:   r_skip_inflight <= r_skip_inflight + IMG_BITWIDTH'(1);
                2'b01:   r_skip_inflight <= r_skip_inflight - IMG_BITWIDTH'(1);
                default: r_skip_inflight <= r_skip_inflight;
            endcase
            if (w_rsp_keep) begin
                r_rsp_col  <= r_rsp_col + IMG_BITWIDTH'(1);
                r_rsp_hacc <= r_rsp_hacc + r_h_step;
            end

            case (r_state)
                StIdle: begin
                    if (core_start) begin
                        r_dst_w  <= cfg_dst_width;
                        r_dst_h  <= cfg_dst_height;
                        r_h_step <= cfg_h_step;
                        r_v_step <= cfg_v_step;
                        if (cfg_dst_width != '0 && cfg_dst_height != '0) begin
                            r_state         <= StWaitConn;
                            r_connect_ready <= 1'b1;
                            r_busy          <= 1'b1;
                            r_row           <= '0;
                            r_v_acc         <= '0;
                        end
                    end
                end
                StWaitConn: begin
                    if (m_axis_connect_valid) begin
                        r_state         <= StIssue;
                        r_connect_ready <= 1'b0;
                        r_h_acc         <= '0;
                        r_col           <= '0;
                        r_reads_left    <= IMG_BITWIDTH'(1);
                        r_pix_stride    <= 1'b0;
                        r_pix_repeat    <= 1'b0;
                        r_rsp_col       <= '0;
                        r_rsp_hacc      <= '0;
                    end
                end
                StIssue: begin
                    if (w_issue) begin
                        r_read_en     <= 1'b1;
                        r_read_stride <= r_pix_stride;
                        r_read_repeat <= r_pix_repeat;
                        if (!w_last_read) begin
                            r_reads_left <= r_reads_left - IMG_BITWIDTH'(1);
                        end else if (r_col == r_dst_w - IMG_BITWIDTH'(1)) begin
                            r_state <= StDrain;
                        end else begin
                            r_col        <= r_col + IMG_BITWIDTH'(1);
                            r_h_acc      <= w_next_hacc;
                            r_reads_left <= (w_delta == '0) ? IMG_BITWIDTH'(1) : w_delta;
                            r_pix_stride <= (w_delta != '0);
                            r_pix_repeat <= (w_delta == '0);
                        end
                    end
                end
                StDrain: begin
                    if (r_kept_inflight == '0 && r_skip_inflight == '0) begin
                        r_state     <= StRowEnd;
                        r_read_done <= 1'b1;
                        r_row_step  <= w_next_vacc[ACC_BITS-1:FRAC_BITWIDTH] -
                                       r_v_acc[ACC_BITS-1:FRAC_BITWIDTH];
                        r_v_acc     <= w_next_vacc;
                    end
                end
                StRowEnd: begin
                    r_row_step <= '0;
                    if (r_row == r_dst_h - IMG_BITWIDTH'(1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_row           <= r_row + IMG_BITWIDTH'(1);
                        r_state         <= StWaitConn;
                        r_connect_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_head = w_fifo_valid ? w_fifo_out : '0;

    assign m_axis_connect_ready   = r_connect_ready;
    assign matrix_ram_read_en     = r_read_en;
    assign matrix_ram_read_stride = r_read_stride;
    assign matrix_ram_read_repeat = r_read_repeat;
    assign matrix_ram_read_done   = r_read_done;
    assign matrix_row_step        = r_row_step;
    assign busy                   = r_busy;
    assign m_win_valid            = w_fifo_valid;
    assign m_win_pixel            = w_head[FIFO_W-1 -: WIN_BITS];
    assign m_win_hphase           = w_head[2*FRAC_BITWIDTH+1 -: FRAC_BITWIDTH];
    assign m_win_vphase           = w_head[FRAC_BITWIDTH+1 -: FRAC_BITWIDTH];
    assign m_win_eol              = w_head[1];
    assign m_win_eof              = w_head[0];

endmodule

// File: tb/tb_scaler_matrix_fetch.sv
// Directed scoreboard bench for scaler_matrix_fetch with a latency-2 matrix RAM model.
module tb_scaler_matrix_fetch;
    localparam int unsigned PIX   = 8;
    localparam int unsigned K     = 4;
    localparam int unsigned IMG   = 12;
    localparam int unsigned FRAC  = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIN   = PIX * K * K;
    localparam int unsigned ACC   = IMG + FRAC;
    localparam int unsigned CW    = WIN + 64;

    typedef struct packed {
        logic [WIN-1:0]  pixel;
        logic [FRAC-1:0] hphase;
        logic [FRAC-1:0] vphase;
        logic            eol;
        logic            eof;
    } win_t;

    logic            core_clk, core_rst, core_start;
    logic [IMG-1:0]  cfg_dst_width, cfg_dst_height;
    logic [ACC-1:0]  cfg_h_step, cfg_v_step;
    logic            m_axis_connect_ready, m_axis_connect_valid;
    logic            rd_en, rd_stride, rd_repeat, rsp_en, rd_done;
    logic [WIN-1:0]  rsp_pixel;
    logic [IMG-1:0]  row_step;
    logic            m_win_valid, m_win_ready, m_win_eol, m_win_eof, busy;
    logic [WIN-1:0]  m_win_pixel;
    logic [FRAC-1:0] m_win_hphase, m_win_vphase;

    scaler_matrix_fetch #(
        .PIXEL_BITWIDTH (PIX),
        .KERNEL_MAX     (K),
        .IMG_BITWIDTH   (IMG),
        .FRAC_BITWIDTH  (FRAC),
        .RSP_FIFO_DEPTH (DEPTH)
    ) dut (
        .core_clk                  (core_clk),
        .core_rst                  (core_rst),
        .core_start                (core_start),
        .cfg_dst_width             (cfg_dst_width),
        .cfg_dst_height            (cfg_dst_height),
        .cfg_h_step                (cfg_h_step),
        .cfg_v_step                (cfg_v_step),
        .m_axis_connect_ready      (m_axis_connect_ready),
        .m_axis_connect_valid      (m_axis_connect_valid),
        .matrix_ram_read_en        (rd_en),
        .matrix_ram_read_stride    (rd_stride),
        .matrix_ram_read_repeat    (rd_repeat),
        .matrix_ram_read_rsp_en    (rsp_en),
        .matrix_ram_read_rsp_pixel (rsp_pixel),
        .matrix_ram_read_done      (rd_done),
        .matrix_row_step           (row_step),
        .m_win_valid               (m_win_valid),
        .m_win_ready               (m_win_ready),
        .m_win_pixel               (m_win_pixel),
        .m_win_hphase              (m_win_hphase),
        .m_win_vphase              (m_win_vphase),
        .m_win_eol                 (m_win_eol),
        .m_win_eof                 (m_win_eof),
        .busy                      (busy)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    win_t           exp_win[$];
    logic [1:0]     exp_rd[$];
    logic [IMG-1:0] exp_step[$];
    int             checks = 0;
    int             errors = 0;
    bit             mon_en = 1'b0;
    bit             hold   = 1'b0;
    int             rd_count = 0;
    int             row_tag  = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIN-1:0] mk_pixel(input int row, input int col);
        logic [31:0] v;
        v = {row[15:0], col[15:0]};
        return {{(WIN-32){1'b0}}, v} ^ {4{v}};
    endfunction

    // RAM model, output monitor and ready driver, all sampled on the falling edge.
    initial begin : monitor
        logic [WIN-1:0] pipe_d[2];
        logic           pipe_v[2];
        int             src_col;
        bit             stall_seen;
        win_t           snap, cur;
        pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
        pipe_d[0] = '0;   pipe_d[1] = '0;
        src_col = 0; stall_seen = 1'b0;
        rsp_en = 1'b0; rsp_pixel = '0; m_win_ready = 1'b1;
        forever begin
            @(negedge core_clk);
            m_win_ready = !hold;
            rsp_en    = pipe_v[0];
            rsp_pixel = pipe_d[0];
            pipe_v[0] = pipe_v[1];
            pipe_d[0] = pipe_d[1];
            pipe_v[1] = 1'b0;
            if (rd_en) begin
                if (rd_stride) src_col = (src_col + 1) & 12'hfff;
                else if (!rd_repeat) src_col = 0;
                pipe_v[1] = 1'b1;
                pipe_d[1] = mk_pixel(row_tag, src_col);
                rd_count++;
                if (mon_en) begin
                    check("read_expected", CW'(exp_rd.size() > 0), CW'(1));
                    if (exp_rd.size() > 0) check("read_flags", CW'({rd_stride, rd_repeat}),
                                                 CW'(exp_rd.pop_front()));
                end
            end else if (mon_en) begin
                check("idle_flags", CW'({rd_stride, rd_repeat}), CW'(0));
            end
            if (rd_done) begin
                row_tag++;
                if (mon_en) begin
                    check("step_expected", CW'(exp_step.size() > 0), CW'(1));
                    if (exp_step.size() > 0) check("row_step", CW'(row_step),
                                                   CW'(exp_step.pop_front()));
                end
            end
            cur = '{m_win_pixel, m_win_hphase, m_win_vphase, m_win_eol, m_win_eof};
            if (mon_en && m_win_valid) begin
                if (stall_seen) check("win_stable", CW'(cur), CW'(snap));
                if (m_win_ready) begin
                    stall_seen = 1'b0;
                    check("win_expected", CW'(exp_win.size() > 0), CW'(1));
                    if (exp_win.size() > 0) check("window", CW'(cur), CW'(exp_win.pop_front()));
                end else begin
                    stall_seen = 1'b1;
                    snap       = cur;
                end
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    task automatic run_frame(input int w, input int h, input logic [ACC-1:0] hs,
                             input logic [ACC-1:0] vs);
        logic [ACC-1:0] hacc, vacc, vnext;
        logic [IMG-1:0] col, prev_col, d;
        win_t           e;
        row_tag = 0;
        vacc = '0;
        if (w != 0 && h != 0) begin
            for (int r = 0; r < h; r++) begin
                vnext = vacc + vs;
                exp_step.push_back(vnext[ACC-1:FRAC] - vacc[ACC-1:FRAC]);
                hacc = '0;
                prev_col = '0;
                for (int c = 0; c < w; c++) begin
                    col = hacc[ACC-1:FRAC];
                    if (c == 0) exp_rd.push_back(2'b00);
                    else begin
                        d = col - prev_col;
                        if (d == '0) exp_rd.push_back(2'b01);
                        else for (int k = 0; k < int'(d); k++) exp_rd.push_back(2'b10);
                    end
                    e.pixel  = mk_pixel(r, int'(col));
                    e.hphase = hacc[FRAC-1:0];
                    e.vphase = vacc[FRAC-1:0];
                    e.eol    = (c == w - 1);
                    e.eof    = (c == w - 1) && (r == h - 1);
                    exp_win.push_back(e);
                    prev_col = col;
                    hacc = hacc + hs;
                end
                vacc = vnext;
            end
        end
        @(posedge core_clk); #2;
        cfg_dst_width  = IMG'(w);
        cfg_dst_height = IMG'(h);
        cfg_h_step     = hs;
        cfg_v_step     = vs;
        core_start     = 1'b1;
        @(posedge core_clk); #2;
        core_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge core_clk); #2;
            if (!busy && exp_win.size() == 0 && exp_rd.size() == 0 && exp_step.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, CW'(done), CW'(1));
    endtask

    function automatic logic [CW-1:0] all_outputs();
        return CW'({m_axis_connect_ready, rd_en, rd_stride, rd_repeat, rd_done, row_step,
                    m_win_valid, m_win_pixel, m_win_hphase, m_win_vphase, m_win_eol,
                    m_win_eof, busy});
    endfunction

    initial begin
        core_rst = 1'b1; core_start = 1'b0; m_axis_connect_valid = 1'b1;
        cfg_dst_width = '0; cfg_dst_height = '0; cfg_h_step = '0; cfg_v_step = '0;
        repeat (3) @(posedge core_clk);
        #2;
        check("reset_outputs", all_outputs(), CW'(0));
        core_rst = 1'b0;
        mon_en   = 1'b1;

        run_frame(4, 1, 28'h0010000, 28'h0010000);
        wait_idle("frame_unity");
        run_frame(4, 1, 28'h0008000, 28'h0010000);
        wait_idle("frame_upscale");
        run_frame(2, 1, 28'h0028000, 28'h0010000);
        wait_idle("frame_skip");

        hold = 1'b1;
        rd_count = 0;
        run_frame(8, 1, 28'h0010000, 28'h0010000);
        repeat (20) @(posedge core_clk);
        #2;
        check("stall_reads", CW'(rd_count), CW'(DEPTH));
        hold = 1'b0;
        wait_idle("frame_stall");

        run_frame(2, 3, 28'h0010000, 28'h0018000);
        wait_idle("frame_vstep");
        check("busy_low", CW'(busy), CW'(0));

        run_frame(0, 2, 28'h0010000, 28'h0010000);
        repeat (3) @(posedge core_clk);
        #2;
        check("zero_frame", CW'({busy, m_axis_connect_ready, rd_en}), CW'(0));

        hold = 1'b1;
        run_frame(8, 1, 28'h0008000, 28'h0010000);
        repeat (3) @(posedge core_clk);
        #2;
        mon_en = 1'b0;
        core_rst = 1'b1;
        exp_win.delete(); exp_rd.delete(); exp_step.delete();
        @(posedge core_clk); #2;
        core_rst = 1'b0;
        check("midframe_reset", all_outputs(), CW'(0));
        hold = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge core_clk);
        #2;
        check("stale_rsp_ignored", CW'({m_win_valid, busy}), CW'(0));
        run_frame(4, 1, 28'h0010000, 28'h0010000);
        wait_idle("frame_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaler_matrix_fetch.md
SCALER_MATRIX_FETCH -- requirements
Module: scaler_matrix_fetch

Interface
REQ-001 SHALL have parameter PIXEL_BITWIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter KERNEL_MAX, default 4, window edge (KxK).
REQ-003 SHALL have parameter IMG_BITWIDTH, default 12, width of image dimensions.
REQ-004 SHALL have parameter FRAC_BITWIDTH, default 16, fractional bits of scale step and phase.
REQ-005 SHALL have parameter RSP_FIFO_DEPTH, default 4, response buffer entries.
REQ-006 SHALL use one clock and a synchronous, active-high reset: core_clk, core_rst.
REQ-007 Ports, in order:
- core_clk  in  1  clock
- core_rst  in  1  sync active-high reset
- core_start  in  1  pulse; latches cfg_*
- cfg_dst_width, cfg_dst_height  in  IMG_BITWIDTH each  output frame size; 0 = no-op frame
- cfg_h_step, cfg_v_step  in  IMG_BITWIDTH+FRAC_BITWIDTH each  source increment per output pixel/row
- m_axis_connect_ready  out  1  fetch ready for next row window set
- m_axis_connect_valid  in  1  matrix holds a complete row window
- matrix_ram_read_en  out  1  one column read request
- matrix_ram_read_stride  out  1  qualifies read_en: advance source column by one first
- matrix_ram_read_repeat  out  1  qualifies read_en: re-read current column
- matrix_ram_read_rsp_en  in  1  response strobe
- matrix_ram_read_rsp_pixel  in  PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX  response window
- matrix_ram_read_done  out  1  pulse; row finished
- matrix_row_step  out  IMG_BITWIDTH  source rows to retire; valid with read_done
- m_win_valid  out  1;  m_win_ready  in  1  output handshake
- m_win_pixel  out  PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX  window
- m_win_hphase, m_win_vphase  out  FRAC_BITWIDTH each  fractional phase
- m_win_eol, m_win_eof  out  1 each  last pixel of row / of frame
- busy  out  1  frame in progress

Function
REQ-008 States SHALL be IDLE, WAIT_CONN, ISSUE, DRAIN, ROW_END; core_start in IDLE -> WAIT_CONN (zero-size cfg -> stays IDLE); core_start outside IDLE SHALL be ignored.
REQ-009 WAIT_CONN SHALL assert m_axis_connect_ready; transfer when ready&valid; -> ISSUE with h_acc=0.
REQ-010 Per output pixel, delta = floor(h_acc+h_step) - floor(h_acc); first pixel of row issues one read with stride=0, repeat=0; else delta=0 -> one read, repeat=1; delta>=1 -> delta reads, stride=1.
REQ-011 Only the last read per output pixel SHALL produce an output window; responses of skip reads SHALL be discarded.
REQ-012 At most one read_en per cycle; stride and repeat never both high; both 0 whenever read_en=0.
REQ-013 A read SHALL issue only if (FIFO occupancy + in-flight kept reads) < RSP_FIFO_DEPTH; no response ever dropped.
REQ-014 Kept responses SHALL leave in order; hphase = frac(h_acc) at issue, vphase = frac(v_acc) of row.
REQ-015 m_win_* SHALL hold stable while valid&!ready.
REQ-016 After last pixel issued -> DRAIN until in-flight=0 -> ROW_END: one-cycle read_done, matrix_row_step = floor(v_acc+v_step)-floor(v_acc), v_acc += v_step.
REQ-017 ROW_END -> WAIT_CONN, or IDLE after row cfg_dst_height-1; busy low only in IDLE.
REQ-018 m_win_eol on pixel dst_width-1; m_win_eof on eol of last row.
REQ-019 Accumulators SHALL be IMG_BITWIDTH+FRAC_BITWIDTH unsigned; overflow wraps, no saturation.
REQ-020 Response arriving same cycle as output pop SHALL keep occupancy unchanged.

Reset
REQ-021 core_rst SHALL force IDLE, empty FIFO, clear counters; all outputs 0 at reset, including mid-frame; in-flight responses after reset discarded.

Structure
REQ-022 State encoding and window-width constant SHALL reside in shared package scaler_pkg.
REQ-023 Response buffer SHALL be sub-module scaler_fetch_fifo (sync FIFO, show-ahead).

Verification
REQ-024 Width 4, h_step 1.0 -> reads flags: (0,0),(s),(s),(s); 4 windows, eol on 4th.
REQ-025 Width 4, h_step 0.5 -> first, repeat, stride, repeat; hphase 0,0.5,0,0.5.
REQ-026 Width 2, h_step 2.5 -> 1 read then 2 strides (1 discarded); 2 windows out.
REQ-027 m_win_ready held low 20 cycles -> read_en stops at FIFO full, no loss, output stable.
REQ-028 Height 3, v_step 1.5 -> matrix_row_step 1,2,1; eof on last window; busy falls.
REQ-029 core_rst mid-ISSUE -> all outputs 0 next cycle; fresh core_start runs correctly.
